// File: rtl/cr_lz77_comp_ob_arb_if.sv
// Stream bundle for the LZ77 compressor output arbiter: N_SRC packed AXI4-Stream
// inputs on one side and the merged, source-tagged output stream on the other.
interface cr_lz77_comp_ob_arb_if #(
  parameter int N_SRC  = 2,
  parameter int DATA_W = 64,
  parameter int USER_W = 8,
  parameter int SRC_W  = (N_SRC > 1) ? $clog2(N_SRC) : 1
);
  logic [N_SRC-1:0]          src_tvalid;
  logic [N_SRC-1:0]          src_tready;
  logic [N_SRC*DATA_W-1:0]   src_tdata;
  logic [N_SRC*DATA_W/8-1:0] src_tstrb;
  logic [N_SRC*USER_W-1:0]   src_tuser;
  logic [N_SRC-1:0]          src_tlast;

  logic                      out_tvalid;
  logic                      out_tready;
  logic [DATA_W-1:0]         out_tdata;
  logic [DATA_W/8-1:0]       out_tstrb;
  logic [USER_W-1:0]         out_tuser;
  logic                      out_tlast;
  logic [SRC_W-1:0]          out_tid;

  // The arbiter is the slave: it consumes the source streams and produces the output.
  modport slave (
    input  src_tvalid, src_tdata, src_tstrb, src_tuser, src_tlast, out_tready,
    output src_tready, out_tvalid, out_tdata, out_tstrb, out_tuser, out_tlast, out_tid
  );

  modport master (
    output src_tvalid, src_tdata, src_tstrb, src_tuser, src_tlast, out_tready,
    input  src_tready, out_tvalid, out_tdata, out_tstrb, out_tuser, out_tlast, out_tid
  );
endinterface

// File: rtl/cr_lz77_comp_ob_arb.sv
// Frame-granular round-robin merge of N_SRC compressor streams through a 2-entry skid buffer.
// Optional stall watchdog on arb_int is enabled by defining CR_LZ77_COMP_OB_ARB_WDOG_EN.
module cr_lz77_comp_ob_arb #(
  parameter int N_SRC  = 2,
  parameter int DATA_W = 64,
  parameter int USER_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  cr_lz77_comp_ob_arb_if.slave  bus,
  output logic                  arb_busy,
  output logic [N_SRC-1:0]      frame_done,
  output logic                  arb_int
);
  localparam int SRC_W  = (N_SRC > 1) ? $clog2(N_SRC) : 1;
  localparam int STRB_W = DATA_W / 8;
  localparam int ENT_W  = DATA_W + STRB_W + USER_W + 1 + SRC_W;

  typedef enum logic {IDLE, LOCK} state_t;

  state_t           state;
  logic [SRC_W-1:0] gnt;
  logic [SRC_W-1:0] rr_ptr;
  logic [ENT_W-1:0] mem [2];
  logic             wr_ptr;
  logic             rd_ptr;
  logic [1:0]       count;

  logic             found;
  logic [SRC_W-1:0] win;
  logic [SRC_W:0]   cand;
  logic             not_full;
  logic             sel_valid;
  logic             sel_last;
  logic [DATA_W-1:0] sel_data;
  logic [STRB_W-1:0] sel_strb;
  logic [USER_W-1:0] sel_user;
  logic             push;
  logic             pop;
  logic [SRC_W-1:0] next_ptr;

  // First valid source at or after rr_ptr, wrapping modulo N_SRC.
  always_comb begin
    found = 1'b0;
    win   = '0;
    cand  = '0;
    for (int k = 0; k < N_SRC; k++) begin
      cand = {1'b0, rr_ptr} + (SRC_W+1)'(k);
      if (cand >= (SRC_W+1)'(N_SRC))
        cand = cand - (SRC_W+1)'(N_SRC);
      if (!found && bus.src_tvalid[cand[SRC_W-1:0]]) begin
        found = 1'b1;
        win   = cand[SRC_W-1:0];
      end
    end
  end

  assign not_full  = (count != 2'd2);
  assign sel_valid = bus.src_tvalid[gnt];
  assign sel_last  = bus.src_tlast[gnt];
  assign sel_data  = bus.src_tdata[gnt*DATA_W +: DATA_W];
  assign sel_strb  = bus.src_tstrb[gnt*STRB_W +: STRB_W];
  assign sel_user  = bus.src_tuser[gnt*USER_W +: USER_W];
  assign push      = (state == LOCK) && sel_valid && not_full;
  assign pop       = (count != 2'd0) && bus.out_tready;
  assign next_ptr  = (gnt == SRC_W'(N_SRC - 1)) ? '0 : gnt + 1'b1;

  // Ready depends only on registered state and occupancy, never on out_tready.
  always_comb begin
    bus.src_tready = '0;
    for (int i = 0; i < N_SRC; i++)
      bus.src_tready[i] = (state == LOCK) && (gnt == SRC_W'(i)) && not_full;
  end

  assign bus.out_tvalid = (count != 2'd0);
  assign {bus.out_tdata, bus.out_tstrb, bus.out_tuser, bus.out_tlast, bus.out_tid} = mem[rd_ptr];
  assign arb_busy = (state == LOCK);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      gnt        <= '0;
      rr_ptr     <= '0;
      frame_done <= '0;
      wr_ptr     <= 1'b0;
      rd_ptr     <= 1'b0;
      count      <= 2'd0;
      for (int e = 0; e < 2; e++)
        mem[e] <= '0;
    end else begin
      frame_done <= '0;
      case (state)
        IDLE: begin
          if (found) begin
            gnt   <= win;
            state <= LOCK;
          end
        end
        LOCK: begin
          if (push && sel_last) begin
            frame_done[gnt] <= 1'b1;
            rr_ptr          <= next_ptr;
            state           <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase

      if (push) begin
        mem[wr_ptr] <= {sel_data, sel_strb, sel_user, sel_last, gnt};
        wr_ptr      <= ~wr_ptr;
      end
      if (pop)
        rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

`ifdef CR_LZ77_COMP_OB_ARB_WDOG_EN
  logic [15:0] stall_cnt;

  // Counts cycles the granted source leaves us waiting; the grant itself is never revoked.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
      arb_int   <= 1'b0;
    end else begin
      if (state == LOCK && !(push && sel_last)) begin
        if (push)
          stall_cnt <= '0;
        else if (!sel_valid && stall_cnt != 16'hFFFF)
          stall_cnt <= stall_cnt + 16'd1;
      end else begin
        stall_cnt <= '0;
      end
      if (stall_cnt == 16'hFFFF)
        arb_int <= 1'b1;
    end
  end
`else
  assign arb_int = 1'b0;
`endif

endmodule

// File: doc/cr_lz77_comp_ob_arb.md
Name: cr_lz77_comp_ob_arb

Overview:
- Frame-granular round-robin arbiter that merges N_SRC LZ77 compressor output streams (AXI4-Stream data path) onto one output stream.
- Sits between the compressor core instances and the shared output register slice / IM split.
- Grant is held from the first beat of a frame until the tlast beat, so frames never interleave.
- Output is registered through a 2-entry skid buffer; the winning source index is driven on out_tid.

Parameters:
N_SRC, 2, number of requesting streams (2..8)
DATA_W, 64, tdata width
USER_W, 8, tuser width; tstrb width is DATA_W/8
SRC_W, $clog2(N_SRC) with a minimum of 1, width of out_tid and grant index

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
src_tvalid  in  N_SRC  per-source valid
src_tready  out  N_SRC  per-source ready
src_tdata  in  N_SRC*DATA_W  per-source data, packed with source 0 in the LSBs
src_tstrb  in  N_SRC*DATA_W/8  per-source byte strobes
src_tuser  in  N_SRC*USER_W  per-source user bits
src_tlast  in  N_SRC  per-source end of frame
out_tvalid  out  1  output valid
out_tready  in  1  output ready
out_tdata  out  DATA_W  output data
out_tstrb  out  DATA_W/8  output byte strobes
out_tuser  out  USER_W  output user bits
out_tlast  out  1  output end of frame
out_tid  out  SRC_W  index of the source that produced the beat
arb_busy  out  1  high while a frame is locked
frame_done  out  N_SRC  one-cycle pulse when a source's tlast beat is accepted by the skid buffer
arb_int  out  1  watchdog interrupt (optional feature)

Behaviour:
- Reset (rst=1 at a clk edge):
  - FSM goes to IDLE; rr_ptr=0; skid buffer emptied.
  - All outputs 0, including src_tready, out_tvalid, frame_done and arb_int.
  - A reset mid-frame drops the partial frame. No recovery beats are emitted.
- FSM has two states, IDLE and LOCK.
- IDLE:
  - Search src_tvalid starting at rr_ptr, wrapping modulo N_SRC; the first asserted source wins.
  - Winner index is registered into gnt; go to LOCK next cycle. No beat is transferred in the arbitration cycle.
  - If no source is valid, stay in IDLE.
- LOCK:
  - src_tready[gnt] = skid-buffer-not-full; every other src_tready is 0.
  - A source beat transfers on src_tvalid[gnt] & src_tready[gnt].
  - When a transferred beat has tlast=1:
    - pulse frame_done[gnt];
    - set rr_ptr = (gnt+1) mod N_SRC;
    - return to IDLE next cycle.
  - A frame consisting of a single tlast beat is legal: 1 beat in LOCK, then IDLE.
- Skid buffer:
  - 2 entries; each entry holds {tdata, tstrb, tuser, tlast, tid}.
  - out_* are driven from the head entry, so latency from source handshake to out_tvalid is 1 cycle.
  - Not-full is computed from registered occupancy only, so there is no combinational path from out_tready to src_tready.
  - Enqueue and dequeue in the same cycle with 1 entry held: occupancy stays 1.
  - Full (2 entries): source ready is 0 until a dequeue occurs.
  - Sustained throughput is 1 beat/clk while out_tready=1, plus 1 idle arbitration cycle per frame.
- Protocol rules:
  - Output payload is held stable while out_tvalid=1 and out_tready=0.
  - Sources must not drop tvalid without a handshake (AXI rule); a violation is not checked.
- arb_busy = (state==LOCK).
- When several sources request simultaneously, round-robin order guarantees each is served within N_SRC frames.

Optional Feature:
- Macro: CR_LZ77_COMP_OB_ARB_WDOG_EN.
- When defined:
  - A 16-bit stall counter increments each cycle in LOCK with src_tvalid[gnt]=0.
  - The counter clears on every granted beat and on the transition to IDLE.
  - When the count reaches 16'hFFFF, arb_int is set. It is sticky until rst.
  - The grant is NOT released by the watchdog.
- When undefined: arb_int is tied 0 and no counter logic exists.

Test Plan:
- Frame framing: src0 sends a 3-beat frame, out_tready=1.
  - Expected: out_tid=0 for 3 consecutive beats, starting 2 cycles after src0 tvalid (arbitration cycle plus 1 cycle of latency); tlast on beat 3; frame_done[0] pulses once.
- Round robin: src0 and src1 both hold 2-beat frames continuously.
  - Expected: frame order on out_tid is 0,1,0,1 and frames never interleave.
- Backpressure: out_tready=0 for 5 cycles mid-frame.
  - Expected: skid buffer holds 2 beats, src_tready[gnt]=0, out payload stable; after release the data is complete and in order.
- Single-beat frames, N_SRC=4, all four sources valid.
  - Expected: grant sequence 0,1,2,3,0; each frame lasts 1 LOCK cycle followed by 1 IDLE cycle.
- Reset mid-frame: assert rst after beat 2 of a 4-beat frame.
  - Expected: next cycle all outputs are 0, state is IDLE and rr_ptr=0; the next frame from any source starts clean.
- Watchdog, with CR_LZ77_COMP_OB_ARB_WDOG_EN defined: src0 sends 1 non-last beat, then tvalid=0 for 65535 cycles.
  - Expected: arb_int=1 and stays 1 after the frame completes.
